// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite register bank (ACLK/ARESET; S_AW/S_W/S_B write, S_AR/S_R read), byte strobes when AXIL_SLAVE_STRB_EN is defined
module axil_regfile_slave #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 32
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic [ADDRESS_WIDTH-1:0] S_AWADDR,
  input  logic S_AWVALID,
  output logic S_AWREADY,
  input  logic [DATA_WIDTH-1:0] S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic S_WVALID,
  output logic S_WREADY,
  output logic [1:0] S_BRESP,
  output logic S_BVALID,
  input  logic S_BREADY,
  input  logic [ADDRESS_WIDTH-1:0] S_ARADDR,
  input  logic S_ARVALID,
  output logic S_ARREADY,
  output logic [DATA_WIDTH-1:0] S_RDATA,
  output logic [1:0] S_RRESP,
  output logic S_RVALID,
  input  logic S_RREADY
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int BYTE_OFFSET = $clog2(NB);
  localparam logic [ADDRESS_WIDTH:0] REG_LIMIT = (ADDRESS_WIDTH + 1)'(NUM_REGS);
  typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [ADDRESS_WIDTH-1:0] aw_addr_q, w_addr, w_idx, r_idx;
  logic [DATA_WIDTH-1:0] w_data_q, w_data, w_mask, r_word;
  logic aw_fire, w_fire, ar_fire, do_write, w_ok, r_ok;
  assign aw_fire = S_AWVALID && S_AWREADY;
  assign w_fire = S_WVALID && S_WREADY;
  assign ar_fire = S_ARVALID && S_ARREADY;
  assign w_addr = (w_state == W_HAVE_ADDR) ? aw_addr_q : S_AWADDR;
  assign w_data = (w_state == W_HAVE_DATA) ? w_data_q : S_WDATA;
  assign w_idx = w_addr >> BYTE_OFFSET;
  assign r_idx = S_ARADDR >> BYTE_OFFSET;
  assign w_ok = {1'b0, w_idx} < REG_LIMIT;
  assign r_ok = {1'b0, r_idx} < REG_LIMIT;
`ifdef AXIL_SLAVE_STRB_EN
  logic [NB-1:0] w_strb_q, w_strb;
  assign w_strb = (w_state == W_HAVE_DATA) ? w_strb_q : S_WSTRB;
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NB; k++) w_mask[8*k +: 8] = {8{w_strb[k]}};
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) w_strb_q <= '0;
    else if (w_fire) w_strb_q <= S_WSTRB;
`else
  logic strb_unused;
  assign strb_unused = ^S_WSTRB;
  assign w_mask = '1;
`endif
  always_comb begin
    w_next = w_state;
    do_write = 1'b0;
    case (w_state)
      W_IDLE: begin
        do_write = aw_fire && w_fire;
        w_next = do_write ? W_RESP : aw_fire ? W_HAVE_ADDR : w_fire ? W_HAVE_DATA : W_IDLE;
      end
      W_HAVE_ADDR: begin
        do_write = w_fire;
        w_next = w_fire ? W_RESP : W_HAVE_ADDR;
      end
      W_HAVE_DATA: begin
        do_write = aw_fire;
        w_next = aw_fire ? W_RESP : W_HAVE_DATA;
      end
      default: w_next = (S_BVALID && S_BREADY) ? W_IDLE : W_RESP;
    endcase
  end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      w_state <= W_IDLE;
      S_AWREADY <= 1'b0;
      S_WREADY <= 1'b0;
      S_BVALID <= 1'b0;
      S_BRESP <= 2'b00;
      aw_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      w_state <= w_next;
      S_AWREADY <= (w_next == W_IDLE) || (w_next == W_HAVE_DATA);
      S_WREADY <= (w_next == W_IDLE) || (w_next == W_HAVE_ADDR);
      S_BVALID <= w_next == W_RESP;
      if (do_write) S_BRESP <= w_ok ? 2'b00 : 2'b10;
      if (aw_fire) aw_addr_q <= S_AWADDR;
      if (w_fire) w_data_q <= S_WDATA;
    end
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) regs <= '{default: '0};
    else
      for (int r = 0; r < NUM_REGS; r++)
        if (do_write && w_idx == ADDRESS_WIDTH'(r)) regs[r] <= (regs[r] & ~w_mask) | (w_data & w_mask);
  always_comb begin
    r_word = '0;
    for (int r = 0; r < NUM_REGS; r++) r_word = (r_idx == ADDRESS_WIDTH'(r)) ? regs[r] : r_word;
  end
  assign r_next = (r_state == R_IDLE) ? (ar_fire ? R_DATA : R_IDLE) : ((S_RVALID && S_RREADY) ? R_IDLE : R_DATA);
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      r_state <= R_IDLE;
      S_ARREADY <= 1'b0;
      S_RVALID <= 1'b0;
      S_RDATA <= '0;
      S_RRESP <= 2'b00;
    end else begin
      r_state <= r_next;
      S_ARREADY <= r_next == R_IDLE;
      S_RVALID <= r_next == R_DATA;
      if (ar_fire) begin
        S_RDATA <= r_ok ? r_word : '0;
        S_RRESP <= r_ok ? 2'b00 : 2'b10;
      end
    end
endmodule
